// File: rtl/vga_timing_gen.sv
// Raster scan generator: divides the system clock down to a pixel tick and walks
// column/row over the full line/frame, with registered sync, blanking and frame strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       pixelTick,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] column,
    output logic [9:0] row,
    output logic       displayActive,
    output logic       frameStart,
    output logic       vblankStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON   = (SYNC_POL != 0);

    // Positions are carried in 10 bits, so larger rasters cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: unsupported parameter set");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic [9:0]       column_q, column_d;
    logic [9:0]       row_q, row_d;
    logic             active_q, active_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_q, frame_d;
    logic             vblank_q, vblank_d;
    logic [9:0]       col_nxt, row_nxt;

    always_comb begin
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        column_d  = column_q;
        row_d     = row_q;
        active_d  = active_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        frame_d   = 1'b0;
        vblank_d  = 1'b0;
        col_nxt   = (column_q == H_LAST) ? 10'd0 : column_q + 10'd1;
        row_nxt   = row_q;
        if (column_q == H_LAST) begin
            row_nxt = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
        end

        if (!enable) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // Decode from the next position so every output lines up with column/row.
        if (tick_d) begin
            column_d = col_nxt;
            row_d    = row_nxt;
            active_d = (col_nxt < H_VIS) && (row_nxt < V_VIS);
            hsync_d  = ((col_nxt >= HS_FIRST) && (col_nxt <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
            vsync_d  = ((row_nxt >= VS_FIRST) && (row_nxt <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
            frame_d  = (col_nxt == 10'd0) && (row_nxt == 10'd0);
            vblank_d = (col_nxt == 10'd0) && (row_nxt == V_VIS);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            column_q  <= H_LAST;
            row_q     <= V_LAST;
            active_q  <= 1'b0;
            hsync_q   <= ~SYNC_ON;
            vsync_q   <= ~SYNC_ON;
            frame_q   <= 1'b0;
            vblank_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            column_q  <= column_d;
            row_q     <= row_d;
            active_q  <= active_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            frame_q   <= frame_d;
            vblank_q  <= vblank_d;
        end
    end

    assign pixelTick     = tick_q;
    assign column        = column_q;
    assign row           = row_q;
    assign displayActive = active_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign frameStart    = frame_q;
    assign vblankStart   = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries driven in lockstep, each compared every clk
// against a linear pixel-index model, plus vector table and targeted timing sequences.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, div;
    } geo_t;

    typedef struct {
        int p;
        int run;
        bit tick;
    } mdl_t;

    typedef struct {
        bit          rst;
        bit          en;
        logic [25:0] exp;
    } vec_t;

    localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 4;
    localparam int S_VA = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_DIV = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;

    logic       tick0, hs0, vs0, da0, fs0, vb0;
    logic       tick1, hs1, vs1, da1, fs1, vb1;
    logic       tick2, hs2, vs2, da2, fs2, vb2;
    logic [9:0] col0, row0, col1, row1, col2, row2;
    logic [25:0] o0, o1, o2;

    int checks = 0;
    int failures = 0;
    int clk_n = 0;
    geo_t g0, g1, g2;
    mdl_t m0, m1, m2;

    always #5 clk = ~clk;

    vga_timing_gen u0 (
        .clk(clk), .rst(rst), .enable(enable), .pixelTick(tick0), .hsync(hs0), .vsync(vs0),
        .column(col0), .row(row0), .displayActive(da0), .frameStart(fs0), .vblankStart(vb0)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .SYNC_POL(0), .CLK_DIV(S_DIV)
    ) u1 (
        .clk(clk), .rst(rst), .enable(enable), .pixelTick(tick1), .hsync(hs1), .vsync(vs1),
        .column(col1), .row(row1), .displayActive(da1), .frameStart(fs1), .vblankStart(vb1)
    );

    vga_timing_gen #(.SYNC_POL(1), .CLK_DIV(1)) u2 (
        .clk(clk), .rst(rst), .enable(enable), .pixelTick(tick2), .hsync(hs2), .vsync(vs2),
        .column(col2), .row(row2), .displayActive(da2), .frameStart(fs2), .vblankStart(vb2)
    );

    assign o0 = {tick0, hs0, vs0, col0, row0, da0, fs0, vb0};
    assign o1 = {tick1, hs1, vs1, col1, row1, da1, fs1, vb1};
    assign o2 = {tick2, hs2, vs2, col2, row2, da2, fs2, vb2};

    // Scan position is a single pixel index p into the frame; reset parks it on the last pixel.
    function automatic mdl_t mstep(mdl_t m, geo_t g, logic r, logic en);
        mdl_t n;
        int total;
        total = (g.ha + g.hfp + g.hs + g.hbp) * (g.va + g.vfp + g.vs + g.vbp);
        n = m;
        n.tick = 1'b0;
        if (r) begin
            n.p = total - 1;
            n.run = 0;
        end else if (en) begin
            n.run = m.run + 1;
            if (n.run % g.div == 0) begin
                n.tick = 1'b1;
                n.p = (m.p + 1) % total;
            end
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    function automatic logic [25:0] expect_out(mdl_t m, geo_t g);
        int ht, col, rw;
        logic on_lvl, hsl, vsl, da, fs, vb;
        ht = g.ha + g.hfp + g.hs + g.hbp;
        col = m.p % ht;
        rw = m.p / ht;
        on_lvl = (g.pol != 0);
        hsl = (col >= g.ha + g.hfp && col < g.ha + g.hfp + g.hs) ? on_lvl : !on_lvl;
        vsl = (rw >= g.va + g.vfp && rw < g.va + g.vfp + g.vs) ? on_lvl : !on_lvl;
        da = (col < g.ha) && (rw < g.va);
        fs = m.tick && (m.p == 0);
        vb = m.tick && (m.p == g.va * ht);
        return {m.tick, hsl, vsl, 10'(col), 10'(rw), da, fs, vb};
    endfunction

    task automatic check(string name, logic [25:0] act, logic [25:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic checki(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m0 = mstep(m0, g0, rst, enable);
        m1 = mstep(m1, g1, rst, enable);
        m2 = mstep(m2, g2, rst, enable);
        clk_n++;
        #1;
        check("model_dut0", o0, expect_out(m0, g0));
        check("model_dut1", o1, expect_out(m1, g1));
        check("model_dut2", o2, expect_out(m2, g2));
    endtask

    initial begin
        vec_t vt[8];
        int hs_cnt, da_cnt, hs_first, start, line_clks, found, bad;
        int fs_n, t1, t2, vb_n, vb_pos, n, ticks, iters;
        logic [31:0] vmask;

        g0 = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 2};
        g1 = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 0, S_DIV};
        g2 = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1};
        m0 = '{0, 0, 1'b0};
        m1 = '{0, 0, 1'b0};
        m2 = '{0, 0, 1'b0};

        // {tick, hsync, vsync, column, row, displayActive, frameStart, vblankStart}
        vt[0] = '{1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 10'd799, 10'd524, 1'b0, 1'b0, 1'b0}};
        vt[1] = '{1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 10'd799, 10'd524, 1'b0, 1'b0, 1'b0}};
        vt[2] = '{1'b0, 1'b1, {1'b1, 1'b1, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b0}};
        vt[3] = '{1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 10'd0,   10'd0,   1'b1, 1'b0, 1'b0}};
        vt[4] = '{1'b0, 1'b1, {1'b1, 1'b1, 1'b1, 10'd1,   10'd0,   1'b1, 1'b0, 1'b0}};
        vt[5] = '{1'b0, 1'b0, {1'b0, 1'b1, 1'b1, 10'd1,   10'd0,   1'b1, 1'b0, 1'b0}};
        vt[6] = '{1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 10'd1,   10'd0,   1'b1, 1'b0, 1'b0}};
        vt[7] = '{1'b0, 1'b1, {1'b1, 1'b1, 1'b1, 10'd2,   10'd0,   1'b1, 1'b0, 1'b0}};

        for (int i = 0; i < 8; i++) begin
            rst = vt[i].rst;
            enable = vt[i].en;
            cyc();
            check($sformatf("vec%0d", i), o0, vt[i].exp);
        end

        // One full line on the default geometry.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        enable = 1'b1;
        hs_cnt = 0; da_cnt = 0; hs_first = -1; start = -1; line_clks = -1;
        for (int i = 0; i < 2000 && line_clks < 0; i++) begin
            cyc();
            if (tick0) begin
                if (row0 == 10'd0) begin
                    if (!hs0) begin
                        hs_cnt++;
                        if (hs_first < 0) hs_first = int'(col0);
                    end
                    da_cnt += int'(da0);
                    if (col0 == 10'd0) start = clk_n;
                end else if (row0 == 10'd1 && col0 == 10'd0) begin
                    line_clks = clk_n - start;
                end
            end
        end
        checki("hsync_low_ticks", hs_cnt, 96);
        checki("hsync_first_col", hs_first, 656);
        checki("active_ticks_line", da_cnt, 640);
        checki("line_clks", line_clks, 1600);

        // Freeze at (300,1).
        found = 0;
        for (int i = 0; i < 1500; i++) begin
            cyc();
            if (tick0 && col0 == 10'd300 && row0 == 10'd1) begin
                found = 1;
                break;
            end
        end
        checki("freeze_reach", found, 1);
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (tick0 || fs0 || vb0 || col0 != 10'd300 || row0 != 10'd1) bad++;
        end
        checki("freeze_hold", bad, 0);
        enable = 1'b1;
        cyc();
        checki("resume_no_early_tick", int'(tick0), 0);
        cyc();
        checki("resume_pos", int'({tick0, col0, row0}), int'({1'b1, 10'd301, 10'd1}));

        // Whole-frame timing on the reduced geometry.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        fs_n = 0; t1 = 0; t2 = 0; vb_n = 0; vb_pos = -1; da_cnt = 0; vmask = '0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (tick1) begin
                if (fs1) begin
                    fs_n++;
                    if (fs_n == 1) t1 = clk_n;
                    else begin
                        t2 = clk_n;
                        break;
                    end
                end
                if (fs_n == 1) begin
                    da_cnt += int'(da1);
                    if (!vs1 && row1 < 10'd32) vmask[row1[4:0]] = 1'b1;
                    if (vb1) begin
                        vb_n++;
                        vb_pos = int'({col1, row1});
                    end
                end
            end
        end
        checki("frame_clks", t2 - t1, 1275);
        checki("active_ticks_frame", da_cnt, 160);
        checki("vsync_rows", int'(vmask), 32'h0000_3000);
        checki("vblank_count", vb_n, 1);
        checki("vblank_pos", vb_pos, int'({10'd0, 10'd10}));

        // Asynchronous reset in the middle of vsync.
        found = 0;
        for (int i = 0; i < 1400; i++) begin
            cyc();
            if (tick1 && row1 == 10'd13 && col1 == 10'd20) begin
                found = 1;
                break;
            end
        end
        checki("midrst_reach", int'({found[0], vs1}), int'({1'b1, 1'b0}));
        #3;
        rst = 1'b1;
        #1;
        checki("async_rst_dut1", int'({vs1, col1, row1, tick1}), int'({1'b1, 10'd24, 10'd16, 1'b0}));
        checki("async_rst_dut0", int'({hs0, vs0, col0, row0, da0}), int'({1'b1, 1'b1, 10'd799, 10'd524, 1'b0}));
        checki("async_rst_idle_pol1", int'({hs2, vs2}), 0);
        cyc();
        rst = 1'b0;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (fs1) begin
                n = i;
                break;
            end
        end
        checki("restart_framestart", n, 3);

        // One line on the CLK_DIV=1, active-high geometry.
        hs_cnt = 0; hs_first = -1; ticks = 0; iters = 0; found = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            iters++;
            ticks += int'(tick2);
            if (row2 == 10'd0 && hs2) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(col2);
            end
            if (row2 == 10'd1 && col2 == 10'd0) begin
                found = 1;
                break;
            end
        end
        checki("div1_line_reach", found, 1);
        checki("div1_tick_rate", ticks, iters);
        checki("pol1_hsync_ticks", hs_cnt, 96);
        checki("pol1_hsync_first", hs_first, 656);

        // Random enable/reset traffic, checked cycle by cycle against the models.
        for (int i = 0; i < 4000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
